// File: rtl/id_pkg.sv
// Shared encodings for the decode stage: branch types as produced by the
// control unit, and the operand-forwarding select codes used in ID.
package id_pkg;

    // Branch type encodings carried on dec_br_type.
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;
    localparam logic [2:0] BR_JAL  = 3'd7;

    // Operand source selects, lowest to highest priority.
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_EX  = 2'd3;

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two combinational read ports with
// write-through bypass, one write port, and a raw debug read port.
// x0 always reads zero and is never written.
module id_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RAW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RAW-1:0]  waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RAW-1:0]  raddr1,
    input  logic [RAW-1:0]  raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic [RAW-1:0]  dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);

    logic [XLEN-1:0] regs [NREG];

    // Storage: cleared during reset, written when we targets a non-zero register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: a same-cycle write to the addressed register is passed through.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
        if (we && waddr != '0 && waddr == raddr1) rdata1 = wdata;
        if (we && waddr != '0 && waddr == raddr2) rdata2 = wdata;
    end

    // Debug port shows stored contents only, never the in-flight write.
    always_comb begin
        dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];
    end

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage: register read with EX/MEM/WB forwarding, load-use stall
// detection, branch resolution and the ID/EX pipeline register.
//
// Pipeline qualifier semantics: if_valid marks a real instruction in ID;
// ex_valid marks a real instruction in EX. There is no back-pressure from EX:
// a valid ID instruction advances every cycle unless id_stall (held in ID,
// bubble into EX) or id_flush (discarded, bubble into EX) is asserted.
module id_stage_fwd
    import id_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int CTRL_W = 16,
    localparam int RAW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [RAW-1:0]    if_rs1,
    input  logic [RAW-1:0]    if_rs2,
    input  logic [RAW-1:0]    if_rd,
    input  logic [CTRL_W-1:0] dec_ctrl,
    input  logic              dec_rs1_en,
    input  logic              dec_rs2_en,
    input  logic              dec_rd_we,
    input  logic              dec_is_load,
    input  logic [2:0]        dec_br_type,
    input  logic [XLEN-1:0]   dec_imm,
    input  logic [RAW-1:0]    ex_fwd_rd,
    input  logic              ex_fwd_we,
    input  logic              ex_fwd_is_load,
    input  logic [XLEN-1:0]   ex_fwd_wd,
    input  logic [RAW-1:0]    mem_fwd_rd,
    input  logic              mem_fwd_we,
    input  logic [XLEN-1:0]   mem_fwd_wd,
    input  logic [RAW-1:0]    wb_rd,
    input  logic              wb_we,
    input  logic [XLEN-1:0]   wb_wd,
    input  logic              id_flush,
    input  logic [RAW-1:0]    dbg_raddr,
    output logic [XLEN-1:0]   dbg_rdata,
    output logic              id_stall,
    output logic              br_taken,
    output logic [XLEN-1:0]   br_target,
    output logic              ex_valid,
    output logic              ex_rd_we,
    output logic              ex_is_load,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [XLEN-1:0]   ex_imm,
    output logic [RAW-1:0]    ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl
);

    logic [XLEN-1:0] rf_rs1, rf_rs2;
    logic [1:0]      rs1_sel, rs2_sel;
    logic [XLEN-1:0] op1, op2;
    logic            br_cond;
    logic            bubble;

    id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (wb_we),
        .waddr     (wb_rd),
        .wdata     (wb_wd),
        .raddr1    (if_rs1),
        .raddr2    (if_rs2),
        .rdata1    (rf_rs1),
        .rdata2    (rf_rs2),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    // Forwarding select per source: youngest producer wins, x0 never forwards.
    always_comb begin
        rs1_sel = FWD_RF;
        rs2_sel = FWD_RF;
        if (if_rs1 != '0) begin
            if (ex_fwd_we && ex_fwd_rd == if_rs1)        rs1_sel = FWD_EX;
            else if (mem_fwd_we && mem_fwd_rd == if_rs1) rs1_sel = FWD_MEM;
            else if (wb_we && wb_rd == if_rs1)           rs1_sel = FWD_WB;
        end
        if (if_rs2 != '0) begin
            if (ex_fwd_we && ex_fwd_rd == if_rs2)        rs2_sel = FWD_EX;
            else if (mem_fwd_we && mem_fwd_rd == if_rs2) rs2_sel = FWD_MEM;
            else if (wb_we && wb_rd == if_rs2)           rs2_sel = FWD_WB;
        end
    end

    // Operand muxes driven by the forwarding selects.
    always_comb begin
        case (rs1_sel)
            FWD_EX:  op1 = ex_fwd_wd;
            FWD_MEM: op1 = mem_fwd_wd;
            FWD_WB:  op1 = wb_wd;
            default: op1 = rf_rs1;
        endcase
        case (rs2_sel)
            FWD_EX:  op2 = ex_fwd_wd;
            FWD_MEM: op2 = mem_fwd_wd;
            FWD_WB:  op2 = wb_wd;
            default: op2 = rf_rs2;
        endcase
    end

    // Load-use hazard: a load in EX cannot forward yet, so hold ID one cycle.
    always_comb begin
        id_stall = if_valid && !id_flush && ex_fwd_is_load && ex_fwd_we &&
                   (ex_fwd_rd != '0) &&
                   ((dec_rs1_en && ex_fwd_rd == if_rs1) ||
                    (dec_rs2_en && ex_fwd_rd == if_rs2));
    end

    // Branch condition on forwarded operands; taken only for a live, unstalled instruction.
    always_comb begin
        br_cond = 1'b0;
        case (dec_br_type)
            BR_BEQ:  br_cond = (op1 == op2);
            BR_BNE:  br_cond = (op1 != op2);
            BR_BLT:  br_cond = ($signed(op1) <  $signed(op2));
            BR_BGE:  br_cond = ($signed(op1) >= $signed(op2));
            BR_BLTU: br_cond = (op1 <  op2);
            BR_BGEU: br_cond = (op1 >= op2);
            BR_JAL:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
        br_taken  = if_valid && !id_stall && !id_flush && br_cond;
        br_target = if_pc + dec_imm;
    end

    assign bubble = rst || id_flush || id_stall || !if_valid;

    // ID/EX register: load the decoded instruction or insert an all-zero bubble.
    always_ff @(posedge clk) begin
        if (bubble) begin
            ex_valid   <= 1'b0;
            ex_rd_we   <= 1'b0;
            ex_is_load <= 1'b0;
            ex_pc      <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_imm     <= '0;
            ex_rd      <= '0;
            ex_ctrl    <= '0;
        end else begin
            ex_valid   <= 1'b1;
            ex_rd_we   <= dec_rd_we;
            ex_is_load <= dec_is_load;
            ex_pc      <= if_pc;
            ex_rs1_val <= op1;
            ex_rs2_val <= op2;
            ex_imm     <= dec_imm;
            ex_rd      <= if_rd;
            ex_ctrl    <= dec_ctrl;
        end
    end

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed and randomized checks of id_stage_fwd against a behavioural model
// of the register file, forwarding priority, load-use stall and branch rules.
module tb_id_stage_fwd;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int CTRL_W = 16;
    localparam int RAW    = 5;
    localparam int VW     = 3 + RAW + CTRL_W + 4 * XLEN;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              if_valid;
    logic [XLEN-1:0]   if_pc;
    logic [RAW-1:0]    if_rs1, if_rs2, if_rd;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_rs1_en, dec_rs2_en, dec_rd_we, dec_is_load;
    logic [2:0]        dec_br_type;
    logic [XLEN-1:0]   dec_imm;
    logic [RAW-1:0]    ex_fwd_rd;
    logic              ex_fwd_we, ex_fwd_is_load;
    logic [XLEN-1:0]   ex_fwd_wd;
    logic [RAW-1:0]    mem_fwd_rd;
    logic              mem_fwd_we;
    logic [XLEN-1:0]   mem_fwd_wd;
    logic [RAW-1:0]    wb_rd;
    logic              wb_we;
    logic [XLEN-1:0]   wb_wd;
    logic              id_flush;
    logic [RAW-1:0]    dbg_raddr;
    logic [XLEN-1:0]   dbg_rdata;
    logic              id_stall, br_taken;
    logic [XLEN-1:0]   br_target;
    logic              ex_valid, ex_rd_we, ex_is_load;
    logic [XLEN-1:0]   ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [RAW-1:0]    ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;

    always #5 clk = ~clk;

    id_stage_fwd #(.XLEN(XLEN), .NREG(NREG), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc),
        .if_rs1(if_rs1), .if_rs2(if_rs2), .if_rd(if_rd), .dec_ctrl(dec_ctrl),
        .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en), .dec_rd_we(dec_rd_we),
        .dec_is_load(dec_is_load), .dec_br_type(dec_br_type), .dec_imm(dec_imm),
        .ex_fwd_rd(ex_fwd_rd), .ex_fwd_we(ex_fwd_we), .ex_fwd_is_load(ex_fwd_is_load),
        .ex_fwd_wd(ex_fwd_wd), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_we(mem_fwd_we),
        .mem_fwd_wd(mem_fwd_wd), .wb_rd(wb_rd), .wb_we(wb_we), .wb_wd(wb_wd),
        .id_flush(id_flush), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .id_stall(id_stall), .br_taken(br_taken), .br_target(br_target),
        .ex_valid(ex_valid), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
        .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [XLEN-1:0] rf_m [NREG];
    logic [VW-1:0]   exp_q [$];

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        if_valid = 0; if_pc = '0; if_rs1 = '0; if_rs2 = '0; if_rd = '0;
        dec_ctrl = '0; dec_rs1_en = 0; dec_rs2_en = 0; dec_rd_we = 0;
        dec_is_load = 0; dec_br_type = 3'd0; dec_imm = '0;
        ex_fwd_rd = '0; ex_fwd_we = 0; ex_fwd_is_load = 0; ex_fwd_wd = '0;
        mem_fwd_rd = '0; mem_fwd_we = 0; mem_fwd_wd = '0;
        wb_rd = '0; wb_we = 0; wb_wd = '0; id_flush = 0; dbg_raddr = '0;
    endtask

    // Advance one clock and move to a point just after the edge; the model
    // register file follows whatever write port values were held at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_m[i] = '0;
        end else if (wb_we && wb_rd != 0) begin
            rf_m[wb_rd] = wb_wd;
        end
        #1;
    endtask

    task automatic instr(input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs2, input logic [RAW-1:0] rd);
        if_valid = 1; if_rs1 = rs1; if_rs2 = rs2; if_rd = rd;
        dec_rs1_en = 1; dec_rs2_en = 1; dec_rd_we = 1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] ref_op(input logic [RAW-1:0] rs);
        if (rs == 0) return '0;
        if (ex_fwd_we && ex_fwd_rd == rs) return ex_fwd_wd;
        if (mem_fwd_we && mem_fwd_rd == rs) return mem_fwd_wd;
        if (wb_we && wb_rd == rs) return wb_wd;
        return rf_m[rs];
    endfunction

    function automatic logic ref_stall();
        logic hit1, hit2;
        hit1 = dec_rs1_en && (if_rs1 == ex_fwd_rd);
        hit2 = dec_rs2_en && (if_rs2 == ex_fwd_rd);
        return if_valid && !id_flush && ex_fwd_is_load && ex_fwd_we &&
               (ex_fwd_rd != 0) && (hit1 || hit2);
    endfunction

    function automatic logic ref_br();
        logic [XLEN-1:0] a, b;
        logic cond;
        longint sa, sb;
        a = ref_op(if_rs1);
        b = ref_op(if_rs2);
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        case (dec_br_type)
            3'd1: cond = (a == b);
            3'd2: cond = (a != b);
            3'd3: cond = (sa < sb);
            3'd4: cond = (sa >= sb);
            3'd5: cond = ({1'b0, a} < {1'b0, b});
            3'd6: cond = ({1'b0, a} >= {1'b0, b});
            3'd7: cond = 1'b1;
            default: cond = 1'b0;
        endcase
        return if_valid && !id_flush && !ref_stall() && cond;
    endfunction

    function automatic logic [VW-1:0] ref_ex();
        if (rst || id_flush || !if_valid || ref_stall()) return '0;
        return {1'b1, dec_rd_we, dec_is_load, if_rd, dec_ctrl, if_pc,
                ref_op(if_rs1), ref_op(if_rs2), dec_imm};
    endfunction

    function automatic logic [VW-1:0] obs_ex();
        return {ex_valid, ex_rd_we, ex_is_load, ex_rd, ex_ctrl, ex_pc,
                ex_rs1_val, ex_rs2_val, ex_imm};
    endfunction

    function automatic logic [XLEN-1:0] rnd_val();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            default: return XLEN'($urandom);
        endcase
    endfunction

    // ---------------- directed then randomized sequence ----------------
    initial begin
        idle();
        rst = 1;
        if_pc = 32'h40; dec_imm = 32'h4;
        @(negedge clk);
        chk("reset_br_target", br_target, 32'h44);
        chk("reset_stall", {31'd0, id_stall}, 32'd0);
        chk("reset_br_taken", {31'd0, br_taken}, 32'd0);
        tick();
        rst = 0;
        idle();
        dbg_raddr = 5;
        @(negedge clk);
        chk("reset_dbg_x5", dbg_rdata, 32'h0);
        chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);

        // register file write and x0 protection
        wb_we = 1; wb_rd = 5; wb_wd = 32'h1234;
        tick();
        idle(); dbg_raddr = 5;
        @(negedge clk);
        chk("rf_write_x5", dbg_rdata, 32'h1234);
        wb_we = 1; wb_rd = 0; wb_wd = 32'hDEAD;
        tick();
        idle(); dbg_raddr = 0;
        @(negedge clk);
        chk("rf_x0_zero", dbg_rdata, 32'h0);

        // forwarding priority EX > MEM > WB
        instr(3, 0, 4);
        ex_fwd_we = 1; ex_fwd_rd = 3; ex_fwd_wd = 32'hA;
        mem_fwd_we = 1; mem_fwd_rd = 3; mem_fwd_wd = 32'hB;
        wb_we = 1; wb_rd = 3; wb_wd = 32'hC;
        tick();
        chk("fwd_ex_priority", ex_rs1_val, 32'hA);
        chk("fwd_ex_valid", {31'd0, ex_valid}, 32'd1);
        idle();
        instr(0, 0, 4);
        ex_fwd_we = 1; ex_fwd_rd = 0; ex_fwd_wd = 32'hA;
        mem_fwd_we = 1; mem_fwd_rd = 0; mem_fwd_wd = 32'hB;
        wb_we = 1; wb_rd = 0; wb_wd = 32'hC;
        tick();
        chk("fwd_x0_zero", ex_rs1_val, 32'h0);

        // load-use stall, then MEM forwarding of the load data
        idle();
        instr(1, 7, 8);
        ex_fwd_we = 1; ex_fwd_is_load = 1; ex_fwd_rd = 7; ex_fwd_wd = 32'hBAD;
        @(negedge clk);
        chk("loaduse_stall", {31'd0, id_stall}, 32'd1);
        tick();
        chk("loaduse_bubble", {31'd0, ex_valid}, 32'd0);
        chk("loaduse_bubble_rs2", ex_rs2_val, 32'h0);
        ex_fwd_we = 0; ex_fwd_is_load = 0; ex_fwd_rd = 0;
        mem_fwd_we = 1; mem_fwd_rd = 7; mem_fwd_wd = 32'h55;
        @(negedge clk);
        chk("loaduse_released", {31'd0, id_stall}, 32'd0);
        tick();
        chk("loaduse_mem_fwd", ex_rs2_val, 32'h55);
        chk("loaduse_valid", {31'd0, ex_valid}, 32'd1);

        // branch compares: signed vs unsigned
        idle();
        instr(1, 2, 0);
        dec_rd_we = 0;
        ex_fwd_we = 1; ex_fwd_rd = 1; ex_fwd_wd = 32'hFFFF_FFFF;
        mem_fwd_we = 1; mem_fwd_rd = 2; mem_fwd_wd = 32'h1;
        if_pc = 32'h100; dec_imm = 32'h20;
        dec_br_type = 3'd3;
        @(negedge clk);
        chk("blt_taken", {31'd0, br_taken}, 32'd1);
        chk("br_target", br_target, 32'h120);
        dec_br_type = 3'd5;
        #1 chk("bltu_not_taken", {31'd0, br_taken}, 32'd0);
        dec_br_type = 3'd6;
        #1 chk("bgeu_taken", {31'd0, br_taken}, 32'd1);
        dec_br_type = 3'd0;
        #1 chk("none_not_taken", {31'd0, br_taken}, 32'd0);
        tick();

        // flush overrides a load-use hazard and a taken BEQ
        idle();
        instr(7, 7, 3);
        dec_br_type = 3'd1;
        ex_fwd_we = 1; ex_fwd_is_load = 1; ex_fwd_rd = 7; ex_fwd_wd = 32'h9;
        id_flush = 1;
        @(negedge clk);
        chk("flush_stall", {31'd0, id_stall}, 32'd0);
        chk("flush_br", {31'd0, br_taken}, 32'd0);
        tick();
        chk("flush_bubble", {31'd0, ex_valid}, 32'd0);

        // write-through bypass from WB
        idle();
        instr(9, 0, 2);
        wb_we = 1; wb_rd = 9; wb_wd = 32'h77;
        tick();
        chk("wb_bypass", ex_rs1_val, 32'h77);

        // reset during a stall: bubble next cycle and the stall is forgotten
        idle();
        instr(4, 0, 2);
        ex_fwd_we = 1; ex_fwd_is_load = 1; ex_fwd_rd = 4;
        rst = 1;
        tick();
        chk("rst_mid_stall", {31'd0, ex_valid}, 32'd0);
        rst = 0;
        idle();
        instr(4, 0, 2);
        tick();
        chk("after_rst_valid", {31'd0, ex_valid}, 32'd1);
        chk("after_rst_rs1", ex_rs1_val, 32'h0);

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            if_valid       = ($urandom_range(0, 99) < 85);
            if_pc          = XLEN'($urandom);
            if_rs1         = RAW'($urandom_range(0, 7));
            if_rs2         = RAW'($urandom_range(0, 7));
            if_rd          = RAW'($urandom_range(0, 31));
            dec_ctrl       = CTRL_W'($urandom);
            dec_rs1_en     = 1'($urandom);
            dec_rs2_en     = 1'($urandom);
            dec_rd_we      = 1'($urandom);
            dec_is_load    = 1'($urandom);
            dec_br_type    = 3'($urandom);
            dec_imm        = XLEN'($urandom);
            ex_fwd_rd      = RAW'($urandom_range(0, 7));
            ex_fwd_we      = 1'($urandom);
            ex_fwd_is_load = 1'($urandom);
            ex_fwd_wd      = rnd_val();
            mem_fwd_rd     = RAW'($urandom_range(0, 7));
            mem_fwd_we     = 1'($urandom);
            mem_fwd_wd     = rnd_val();
            wb_rd          = RAW'($urandom_range(0, 7));
            wb_we          = 1'($urandom);
            wb_wd          = rnd_val();
            id_flush       = ($urandom_range(0, 99) < 10);
            dbg_raddr      = RAW'($urandom_range(0, 7));
            @(negedge clk);
            chk("rnd_stall", {31'd0, id_stall}, {31'd0, ref_stall()});
            chk("rnd_br_taken", {31'd0, br_taken}, {31'd0, ref_br()});
            chk("rnd_br_target", br_target, if_pc + dec_imm);
            chk("rnd_dbg", dbg_rdata, (dbg_raddr == 0) ? '0 : rf_m[dbg_raddr]);
            exp_q.push_back(ref_ex());
            tick();
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rnd_queue_empty observed=0 expected=1");
            end else begin
                chk_vec("rnd_id_ex", obs_ex(), exp_q.pop_front());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Time bound so the run always ends even if a wait above never returns.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/id_stage_fwd.md
# id_stage_fwd

Parametrised decode stage for the five-stage pipeline: register file, internal operand-forwarding selection, load-use hazard detection with stall/bubble insertion, branch resolution in ID, and the ID/EX pipeline register. Sits between the IF/ID register and EX and consumes pre-decoded control from the existing control unit. Forwarding-select and stall logic live here instead of in an external hazard unit.

## Interface
- XLEN, 32, datapath width
- NREG, 32, architectural registers; RAW = $clog2(NREG)
- CTRL_W, 16, opaque control bundle passed to EX

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  IF/ID holds a real instruction
- if_pc  in  XLEN  PC of the instruction in ID
- if_rs1, if_rs2, if_rd  in  RAW each  register fields
- dec_ctrl  in  CTRL_W  control bundle from the control unit
- dec_rs1_en, dec_rs2_en  in  1 each  instruction reads rs1/rs2
- dec_rd_we  in  1  instruction writes rd
- dec_is_load  in  1  instruction is a load
- dec_br_type  in  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JAL
- dec_imm  in  XLEN  sign-extended immediate
- ex_fwd_rd  in  RAW, ex_fwd_we  in  1, ex_fwd_is_load  in  1, ex_fwd_wd  in  XLEN  EX-stage producer
- mem_fwd_rd  in  RAW, mem_fwd_we  in  1, mem_fwd_wd  in  XLEN  MEM-stage producer
- wb_rd  in  RAW, wb_we  in  1, wb_wd  in  XLEN  register-file write port
- id_flush  in  1  discard the instruction in ID
- dbg_raddr  in  RAW, dbg_rdata  out  XLEN  debug read port (raw register-file contents, no bypass)
- id_stall  out  1  hold PC and IF/ID this cycle
- br_taken  out  1  redirect fetch
- br_target  out  XLEN  if_pc + dec_imm
- ex_valid, ex_rd_we, ex_is_load  out  1 each
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  XLEN each
- ex_rd  out  RAW; ex_ctrl  out  CTRL_W

## Operation
- Register file: NREG×XLEN. Write on clk when wb_we && wb_rd != 0. x0 reads 0 and is never written. Combinational read.
- Operand selection per source rsN, with priority EX > MEM > WB > register file. A source matches only when its we=1, its rd == rsN, and rsN != 0. A WB match is the write-through bypass for same-cycle write/read.
- Load-use: id_stall = if_valid && !id_flush && ex_fwd_is_load && ex_fwd_we && ex_fwd_rd != 0 && ((dec_rs1_en && ex_fwd_rd == if_rs1) || (dec_rs2_en && ex_fwd_rd == if_rs2)).
- Branch: br_taken = if_valid && !id_stall && !id_flush && condition(dec_br_type) on the forwarded operands. BLT/BGE compare signed; BLTU/BGEU compare unsigned; JAL is always taken; type 0 is never taken. Fetch-side squash of the wrong-path instruction belongs to IF.
- ID/EX register, next-state:
  - rst → bubble.
  - id_flush or id_stall or !if_valid → bubble.
  - Otherwise load the forwarded operands, if_pc, dec_imm, dec_ctrl, if_rd, dec_rd_we, dec_is_load, with ex_valid=1.
- Bubble: ex_valid, ex_rd_we and ex_is_load are 0, and every other field is 0.
- id_flush has priority over stall: id_stall=0 and br_taken=0 while id_flush=1.

## Timing
- Reset: all ID/EX outputs 0; register file cleared to 0 over the single reset cycle. id_stall, br_taken and br_target are combinational. br_target is still computed during reset; the others are 0 when if_valid=0.
- ID→EX latency: 1 cycle.
- id_stall is asserted in the same cycle as the hazard. A load-use stall lasts exactly 1 cycle; the following cycle takes the load data from MEM forwarding.
- Reset asserted mid-stall: ex_valid=0 in the next cycle and the stall is forgotten.
- br_taken depends combinationally on ex_fwd_wd. This is an accepted critical path.

## Structure
- Package id_pkg holds the BR_* encodings (3-bit localparams) and the FWD_RF/WB/MEM/EX select constants.
- Sub-module id_regfile holds the storage, write-through bypass and debug port, parametrised by XLEN and NREG.
- Forwarding, hazard, branch compare and the ID/EX register are in the top module.

## Test plan
- Reset, then dbg_raddr=5 → dbg_rdata=0 and ex_valid=0. Write wb_rd=5, wb_wd=0x1234 → dbg_rdata=0x1234 in the next cycle. Write to x0 → x0 still reads 0.
- rs1=3 matched by EX (0xA), MEM (0xB) and WB (0xC) simultaneously → ex_rs1_val=0xA next cycle. Same case with rs1=0 → 0.
- Load in EX with rd=7 and ID reads rs2=7 → id_stall=1 for one cycle and a bubble goes into EX. Next cycle, MEM forwards 0x55 → ex_rs2_val=0x55.
- BLT with rs1=0xFFFFFFFF and rs2=1 → br_taken=1. BLTU on the same operands → br_taken=0. br_target=if_pc+dec_imm (0x100+0x20=0x120).
- id_flush=1 during a load-use hazard together with a taken BEQ → id_stall=0, br_taken=0, ex_valid=0 next cycle.
- wb_we writes x9=0x77 in the same cycle ID reads x9 with no EX/MEM match → ex_rs1_val=0x77.
